// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential IEEE-754 single-precision multiplier with special-operand handling
// Define FP_MUL_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module fp_mul_seq #(
    parameter int          ITER_BITS = 1,
    parameter logic [31:0] NAN_CODE  = 32'h7FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        err_inf,
    output logic        ovf,
    output logic        unf
);
    localparam int               N_ITER   = 24 / ITER_BITS;
    localparam int               CNT_W    = $clog2(N_ITER);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

    typedef enum logic [2:0] {IDLE, CHECK, MUL, NORM, DONE} state_t;

    state_t            state, state_nxt;
    logic              live_q;
    logic              out_valid_q, out_valid_nxt;
    logic              accept, out_fire;
    logic [30:0]       a_q, b_q;
    logic              sign_q;
    logic [47:0]       mcand_q, acc_q, pp_sum;
    logic [23:0]       mplier_q;
    logic [CNT_W-1:0]  cnt_q;
    logic signed [9:0] exp_q;
    logic [31:0]       res_q;
    logic [2:0]        flag_q;    // {err_inf, ovf, unf}

    logic [7:0]        ea, eb;
    logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic              invalid, special;

    logic [22:0]       mant_t, mant_f;
    logic signed [9:0] exp_t, exp_f;
    logic              norm_ovf, norm_unf;
    logic [31:0]       norm_res;

    // Operand classification; denormals count as zero.
    assign ea      = a_q[30:23];
    assign eb      = b_q[30:23];
    assign zero_a  = (ea == 8'd0);
    assign zero_b  = (eb == 8'd0);
    assign inf_a   = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    assign inf_b   = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    assign nan_a   = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    assign nan_b   = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    assign invalid = nan_a || nan_b || (zero_a && inf_b) || (inf_a && zero_b);
    assign special = invalid || inf_a || inf_b || zero_a || zero_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            live_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            live_q      <= 1'b1;
            out_valid_q <= out_valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CHECK;
            CHECK:   state_nxt = special ? DONE : MUL;
            MUL:     if (cnt_q == LAST_CNT) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (out_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // out_valid is registered, so it rises one cycle after DONE is entered.
    always_comb begin
        in_ready      = live_q && (state == IDLE);
        accept        = in_valid && in_ready;
        out_fire      = out_valid_q && out_ready;
        out_valid_nxt = (state == DONE) && !out_fire;
        out_valid     = out_valid_q;
        result        = res_q;
        err_inf       = out_valid_q && flag_q[2];
        ovf           = out_valid_q && flag_q[1];
        unf           = out_valid_q && flag_q[0];
    end

    always_comb begin
        pp_sum = acc_q;
        for (int i = 0; i < ITER_BITS; i++) begin
            if (mplier_q[i]) pp_sum = pp_sum + (mcand_q << i);
        end
    end

`ifdef FP_MUL_ROUND_NEAREST_EN
    logic        guard, sticky, round_up;
    logic [23:0] mant_rnd;
`endif

    always_comb begin
        if (acc_q[47]) begin
            mant_t = acc_q[46:24];
            exp_t  = exp_q + 10'sd1;
        end else begin
            mant_t = acc_q[45:23];
            exp_t  = exp_q;
        end
`ifdef FP_MUL_ROUND_NEAREST_EN
        guard    = acc_q[47] ? acc_q[23] : acc_q[22];
        sticky   = acc_q[47] ? (|acc_q[22:0]) : (|acc_q[21:0]);
        round_up = guard && (sticky || mant_t[0]);
        mant_rnd = {1'b0, mant_t} + {23'd0, round_up};
        if (mant_rnd[23]) begin
            mant_f = 23'd0;
            exp_f  = exp_t + 10'sd1;
        end else begin
            mant_f = mant_rnd[22:0];
            exp_f  = exp_t;
        end
`else
        mant_f = mant_t;
        exp_f  = exp_t;
`endif
        norm_ovf = (exp_f >= 10'sd255);
        norm_unf = (exp_f <= 10'sd0);
        if (norm_ovf)      norm_res = {sign_q, 31'h7F80_0000};
        else if (norm_unf) norm_res = {sign_q, 31'h0};
        else               norm_res = {sign_q, exp_f[7:0], mant_f};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            res_q    <= '0;
            flag_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q    <= a[30:0];
                        b_q    <= b[30:0];
                        sign_q <= a[31] ^ b[31];
                        flag_q <= '0;
                    end
                end
                CHECK: begin
                    if (invalid) begin
                        res_q  <= NAN_CODE;
                        flag_q <= 3'b100;
                    end else if (inf_a || inf_b) begin
                        res_q <= {sign_q, 31'h7F80_0000};
                    end else if (zero_a || zero_b) begin
                        res_q <= {sign_q, 31'h0};
                    end else begin
                        mcand_q  <= {24'd0, 1'b1, a_q[22:0]};
                        mplier_q <= {1'b1, b_q[22:0]};
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        exp_q    <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
                    end
                end
                MUL: begin
                    acc_q    <= pp_sum;
                    mcand_q  <= mcand_q << ITER_BITS;
                    mplier_q <= mplier_q >> ITER_BITS;
                    cnt_q    <= cnt_q + CNT_W'(1);
                end
                NORM: begin
                    res_q  <= norm_res;
                    flag_q <= {1'b0, norm_ovf, norm_unf};
                end
                DONE: begin
                    if (out_fire) flag_q <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb/tb_fp_mul_seq.sv - self-checking bench for fp_mul_seq (ITER_BITS=1 and 4 side by side)
module tb_fp_mul_seq;
    localparam int ITB [2] = '{1, 4};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic [1:0]  ir, ov;
    logic [31:0] res [2];
    logic [2:0]  flg [2];
    logic        e_w [2], o_w [2], u_w [2];

    int checks = 0, errors = 0, cyc = 0;

    logic [31:0] exp_res;
    logic [2:0]  exp_flg;
    bit          exp_sp;
    int          acc_cyc;
    logic [1:0]  pend = '0, seen = '0;
    logic [31:0] last_res [2];
    logic [2:0]  last_flg [2];

    fp_mul_seq #(.ITER_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]),
        .err_inf(e_w[0]), .ovf(o_w[0]), .unf(u_w[0]));

    fp_mul_seq #(.ITER_BITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]),
        .err_inf(e_w[1]), .ovf(o_w[1]), .unf(u_w[1]));

    assign flg[0] = {e_w[0], o_w[0], u_w[0]};
    assign flg[1] = {e_w[1], o_w[1], u_w[1]};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // IEEE product from the classification rules and plain integer arithmetic.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [2:0] f, output bit sp);
        int ex, ey, e2, sh;
        bit zx, zy, ix, iy, nx, ny, s;
        longint p, m;
`ifdef FP_MUL_ROUND_NEAREST_EN
        longint rem, half;
`endif
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 23'd0);
        iy = (ey == 255) && (y[22:0] == 23'd0);
        nx = (ex == 255) && (x[22:0] != 23'd0);
        ny = (ey == 255) && (y[22:0] != 23'd0);
        s  = x[31] ^ y[31];
        f  = 3'b000;
        sp = 1'b1;
        r  = '0;
        if (nx || ny || (zx && iy) || (ix && zy)) begin
            r = 32'h7FFF_FFFF;
            f = 3'b100;
        end else if (ix || iy) begin
            r = {s, 31'h7F80_0000};
        end else if (zx || zy) begin
            r = {s, 31'h0};
        end else begin
            sp = 1'b0;
            p  = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
            e2 = ex + ey - 127;
            sh = (p >= (longint'(1) << 47)) ? 24 : 23;
            if (sh == 24) e2++;
            m = p >> sh;
`ifdef FP_MUL_ROUND_NEAREST_EN
            rem  = p - (m << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && m[0])) m++;
            if (m == (longint'(1) << 24)) begin
                m = m >> 1;
                e2++;
            end
`endif
            if (e2 >= 255) begin
                r = {s, 31'h7F80_0000};
                f = 3'b010;
            end else if (e2 <= 0) begin
                r = {s, 31'h0};
                f = 3'b001;
            end else begin
                r = {s, 8'(e2), m[22:0]};
            end
        end
    endfunction

    // Compare process: every cycle an output is valid it must match the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = '0;
            seen = '0;
            chk("reset_out_valid", {30'd0, ov}, 32'd0);
        end else begin
            if (in_valid && ir[0] && ir[1]) begin
                model(a, b, exp_res, exp_flg, exp_sp);
                acc_cyc = cyc + 1;
                pend = 2'b11;
                seen = 2'b00;
            end
            for (int k = 0; k < 2; k++) begin
                if (ov[k]) begin
                    chk($sformatf("valid_expected_%0d", k), {31'd0, pend[k]}, 32'd1);
                    if (pend[k]) begin
                        if (!seen[k]) begin
                            chk($sformatf("latency_itb%0d", ITB[k]), 32'(cyc - acc_cyc),
                                32'(exp_sp ? 2 : 3 + 24 / ITB[k]));
                            seen[k] = 1'b1;
                        end
                        chk($sformatf("result_itb%0d", ITB[k]), res[k], exp_res);
                        chk($sformatf("flags_itb%0d", ITB[k]), {29'd0, flg[k]}, {29'd0, exp_flg});
                        if (out_ready) begin
                            pend[k] = 1'b0;
                            last_res[k] = res[k];
                            last_flg[k] = flg[k];
                        end
                    end
                end
            end
        end
    end

    task automatic start(input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        while (ir != 2'b11 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) timeout("in_ready_wait");
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_wait();
        int n = 0;
        while ((pend != 2'b00 || ir != 2'b11) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) timeout("completion_wait");
    endtask

    task automatic txn_lit(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] r, input logic [2:0] f);
        logic [31:0] mr;
        logic [2:0]  mf;
        bit          msp;
        model(x, y, mr, mf, msp);
        chk({"model_", name}, mr, r);
        chk({"model_flags_", name}, {29'd0, mf}, {29'd0, f});
        start(x, y);
        finish_wait();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_itb%0d", name, ITB[k]), last_res[k], r);
            chk($sformatf("%s_flags_itb%0d", name, ITB[k]), {29'd0, last_flg[k]}, {29'd0, f});
        end
    endtask

    task automatic txn(input logic [31:0] x, input logic [31:0] y);
        start(x, y);
        finish_wait();
    endtask

    initial begin
        #23;
        chk("reset_in_ready", {30'd0, ir}, 32'd0);
        chk("reset_result", res[0], 32'd0);
        chk("reset_flags", {29'd0, flg[0]}, 32'd0);
        #9 rst_n = 1'b1;
        #1 chk("in_ready_before_clk", {30'd0, ir}, 32'd0);
        @(posedge clk); #1;
        chk("in_ready_after_clk", {30'd0, ir}, 32'd3);

        txn_lit("mul_2x3",      32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000);
        txn_lit("zero_x_inf",   32'h0000_0000, 32'h7F80_0000, 32'h7FFF_FFFF, 3'b100);
        txn_lit("inf_x_zero",   32'h7F80_0000, 32'h0000_0000, 32'h7FFF_FFFF, 3'b100);
        txn_lit("neg_1p5_x_2",  32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, 3'b000);
        txn_lit("negzero_x_2",  32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 3'b000);
        txn_lit("ovf_max",      32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b010);
        txn_lit("unf_min",      32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b001);
        txn_lit("ovf_edge",     32'h5F80_0000, 32'h5F80_0000, 32'h7F80_0000, 3'b010);
        txn_lit("unf_edge",     32'h2000_0000, 32'h1F80_0000, 32'h0000_0000, 3'b001);
        txn_lit("min_normal",   32'h2000_0000, 32'h2000_0000, 32'h0080_0000, 3'b000);
        txn_lit("big_x_half",   32'h7F00_0000, 32'h3F00_0000, 32'h7E80_0000, 3'b000);
        txn_lit("123_x_m10",    32'h42F6_0000, 32'hC120_0000, 32'hC499_C000, 3'b000);
        txn_lit("nan_x_one",    32'h7FC0_0000, 32'h3F80_0000, 32'h7FFF_FFFF, 3'b100);
        txn_lit("inf_x_m2",     32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 3'b000);
        txn_lit("denorm_x_one", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 3'b000);
        txn_lit("one_x_mone",   32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 3'b000);
        txn(32'h3F80_0001, 32'h3FC0_0000);
        txn(32'h3FFF_FFFF, 32'h3FFF_FFFF);
        txn(32'h4049_0FDB, 32'hC02D_F854);

        // Back-pressure: output held, second request ignored.
        out_ready = 1'b0;
        start(32'h4000_0000, 32'h4040_0000);
        begin
            int n = 0;
            while (!ov[0] && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 100) timeout("hold_valid_wait");
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 32'h3F80_0000;
                b = 32'h3F80_0000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("hold_in_ready", {30'd0, ir}, 32'd0);
            chk("hold_out_valid", {30'd0, ov}, 32'd3);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_out_valid", {30'd0, ov}, 32'd0);
        chk("release_in_ready", {30'd0, ir}, 32'd3);
        chk("hold_final_result", last_res[0], 32'h40C0_0000);

        // Reset in the middle of the ITER_BITS=1 multiply.
        start(32'h4000_0000, 32'h4040_0000);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {30'd0, ov}, 32'd0);
        chk("midreset_in_ready", {30'd0, ir}, 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("rerelease_in_ready", {30'd0, ir}, 32'd0);
        @(posedge clk); #1;
        chk("rerelease_in_ready_clk", {30'd0, ir}, 32'd3);
        txn_lit("rerun_2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Sequencer for the single-precision floating-point multiply datapath.
- Accepts one operand pair per transaction through a valid/ready handshake, then resolves special operands (zero, infinity, NaN, 0×inf).
- For normal operands it runs an iterative shift-add mantissa multiply, then normalises and packs the IEEE-754 result.
- Sits between the ALU issue logic and the FP result writeback, and reports error/overflow/underflow flags with each result.

Parameters:
- ITER_BITS, 1: multiplier bits retired per MUL cycle. Legal values are 1, 2, 3, 4, 6. MUL phase lasts 24/ITER_BITS cycles.
- NAN_CODE, 32'h7FFF_FFFF: canonical NaN emitted for any invalid result.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  32  operand A, IEEE-754 single
- b  input  32  operand B, IEEE-754 single
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  32  product, IEEE-754 single
- err_inf  output  1  invalid operation (NaN produced)
- ovf  output  1  exponent overflow, result is ±inf
- unf  output  1  exponent underflow, result flushed to ±0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0 while in reset, 1 on the first clk after release. out_valid=0, result=0, err_inf=ovf=unf=0. All internal registers are cleared. Reset mid-transaction abandons the operation and produces no output.
- States: IDLE, CHECK, MUL, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register a and b, record sign = a[31]^b[31], go to CHECK.
- CHECK (1 cycle, in_ready=0): classify each operand on bits [30:0]:
  - zero: exp=0. Denormals are flushed to zero.
  - inf: exp=255, mant=0.
  - NaN: exp=255, mant≠0.
- CHECK priority, highest first:
  - NaN in, or 0×inf → NAN_CODE, err_inf=1.
  - inf → {sign, 31'h7F800000}.
  - zero → {sign, 31'h0}.
  - Any special case goes to DONE. Otherwise load multiplicand {1,mantA} and multiplier {1,mantB}, clear the 48-bit accumulator, set exponent = ea+eb−127 (10-bit signed), and go to MUL.
- MUL:
  - Each cycle adds ITER_BITS partial products (LSB first) to the accumulator and shifts.
  - Iteration counter runs 0..24/ITER_BITS−1; on the last count, go to NORM.
- NORM (1 cycle):
  - If product bit47=1: mant = p[46:24], exp+1. Else mant = p[45:23].
  - Truncate (round toward zero) unless the optional feature is enabled.
  - exp ≥ 255 → {sign, 31'h7F800000}, ovf=1.
  - exp ≤ 0 → {sign, 31'h0}, unf=1.
  - Go to DONE.
- DONE:
  - out_valid=1. result and flags stay stable while out_ready=0.
  - On out_ready=1, clear out_valid and flags, and go to IDLE. in_ready=1 on the next cycle; there is no same-cycle re-accept.
- Latency from the accept edge to out_valid:
  - Special case: 2 cycles.
  - Normal operands: 2 + 24/ITER_BITS + 1 cycles (27 with ITER_BITS=1).
- Throughput: one transaction in flight. in_valid is ignored outside IDLE.
- Flags are mutually exclusive and valid only while out_valid=1.

Optional Feature:
- Macro: FP_MUL_ROUND_NEAREST_EN.
- When defined, NORM rounds to nearest-even:
  - guard = first discarded bit; sticky = OR of the remaining discarded bits.
  - Increment the mantissa when guard && (sticky || lsb).
  - A mantissa carry-out renormalises: mant=0, exp+1.
  - Overflow is checked after rounding.
  - Latency is unchanged.
- When undefined, results are truncated and the rounding logic is absent.

Test Plan:
1. a=32'h40000000 (2.0), b=32'h40400000 (3.0), ITER_BITS=1 → result=32'h40C00000, all flags 0, out_valid exactly 27 cycles after accept.
2. a=32'h00000000, b=32'h7F800000 → result=32'h7FFFFFFF, err_inf=1, out_valid 2 cycles after accept. Swapping the operands gives the same result.
3. a=32'hBFC00000 (−1.5), b=32'h40000000 → result=32'hC0400000. a=32'h80000000, b=32'h40000000 → result=32'h80000000 in 2 cycles.
4. a=b=32'h7F000000 → result=32'h7F800000, ovf=1. a=b=32'h00800000 → result=32'h00000000, unf=1.
5. Hold out_ready=0 for 10 cycles after out_valid → result and flags stable, in_ready=0, a second in_valid is ignored. Release out_ready → in_ready=1 on the next cycle.
6. Assert rst_n=0 mid-MUL (cycle 10) → out_valid=0 immediately. After release, test 1 re-runs with correct result and latency. Repeat test 1 with ITER_BITS=4 → latency 9 cycles.
